// File: rtl/poly_sample_rej_pkg.sv
// Shared definitions for the polynomial rejection sampler:
// default geometry, modulus, mode encodings, the uniform-mode mask,
// FSM state encoding and the small mod-5 lookup used by eta2.
package poly_sample_rej_pkg;

    localparam int POLY_N          = 256;
    localparam int POLY_Q          = 8380417;
    localparam int POLY_COEF_W     = 32;
    localparam int POLY_RATE_BYTES = 168;

    // Uniform candidates keep only the low 23 bits of each 3-byte group
    localparam logic [23:0] UNIF_MASK = 24'h7F_FFFF;

    typedef enum logic [1:0] {
        MODE_UNIFORM = 2'd0,
        MODE_ETA2    = 2'd1,
        MODE_ETA4    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BLK = 2'd1,
        ST_SAMPLE   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // t mod 5 for t in 0..14; 15 is always rejected so its value is don't-care
    function automatic logic [2:0] mod5(input logic [3:0] t);
        logic [2:0] r;
        case (t)
            4'd0, 4'd5, 4'd10:  r = 3'd0;
            4'd1, 4'd6, 4'd11:  r = 3'd1;
            4'd2, 4'd7, 4'd12:  r = 3'd2;
            4'd3, 4'd8, 4'd13:  r = 3'd3;
            4'd4, 4'd9, 4'd14:  r = 3'd4;
            default:            r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/poly_sample_cand.sv
// Candidate extractor: picks candidate 'pos' out of the registered
// squeeze block for the active mode and reports whether it is accepted,
// its signed coefficient value and whether it is the block's last one.
// Purely combinational.
module poly_sample_cand
    import poly_sample_rej_pkg::*;
#(
    parameter int RATE_BYTES = POLY_RATE_BYTES,
    parameter int Q          = POLY_Q,
    parameter int COEF_W     = POLY_COEF_W,
    parameter int POS_W      = $clog2(2 * RATE_BYTES)
) (
    input  logic [RATE_BYTES*8-1:0] blk,
    input  logic [POS_W-1:0]        pos,
    input  logic [1:0]              mode,
    output logic                    accept,
    output logic [COEF_W-1:0]       coef,
    output logic                    last
);

    localparam int UNIF_CANDS = RATE_BYTES / 3;
    localparam int ETA_CANDS  = 2 * RATE_BYTES;
    localparam int UIDX_W     = $clog2(UNIF_CANDS);
    localparam logic [23:0] Q_V = 24'(Q);

    logic [7:0]        blk_bytes  [RATE_BYTES];
    logic [23:0]       unif_words [UNIF_CANDS];
    logic [UIDX_W-1:0] unif_idx;
    logic [23:0]       unif_t;
    logic [7:0]        eta_byte;
    logic [3:0]        eta_t;
    logic signed [4:0] eta_v;

    genvar gi;
    for (gi = 0; gi < RATE_BYTES; gi++) begin : g_bytes
        assign blk_bytes[gi] = blk[gi*8 +: 8];
    end
    for (gi = 0; gi < UNIF_CANDS; gi++) begin : g_unif
        assign unif_words[gi] = blk[gi*24 +: 24] & UNIF_MASK;
    end

    assign unif_idx = pos[UIDX_W-1:0];
    assign unif_t   = unif_words[unif_idx];
    assign eta_byte = blk_bytes[pos[POS_W-1:1]];
    // low nibble of each byte is consumed before the high nibble
    assign eta_t    = pos[0] ? eta_byte[7:4] : eta_byte[3:0];

    // Mode-dependent acceptance test, coefficient mapping and end-of-block flag
    always_comb begin
        accept = 1'b0;
        coef   = '0;
        last   = 1'b0;
        eta_v  = '0;
        case (mode)
            MODE_UNIFORM: begin
                accept = (unif_t < Q_V);
                coef   = COEF_W'(unif_t);
                last   = (pos == POS_W'(UNIF_CANDS - 1));
            end
            MODE_ETA2: begin
                accept = (eta_t < 4'd15);
                eta_v  = 5'sd2 - $signed({2'b00, mod5(eta_t)});
                coef   = {{(COEF_W-5){eta_v[4]}}, eta_v};
                last   = (pos == POS_W'(ETA_CANDS - 1));
            end
            MODE_ETA4: begin
                accept = (eta_t < 4'd9);
                eta_v  = 5'sd4 - $signed({1'b0, eta_t});
                coef   = {{(COEF_W-5){eta_v[4]}}, eta_v};
                last   = (pos == POS_W'(ETA_CANDS - 1));
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/poly_sample_rej.sv
// Rejection sampler filling one N-coefficient polynomial from SHAKE
// squeeze blocks (uniform mod Q, eta2 or eta4).
// Optional build macro POLY_SAMPLE_STAT_EN adds saturating blk_cnt /
// rej_cnt statistics outputs; without it the core is unchanged.
module poly_sample_rej
    import poly_sample_rej_pkg::*;
#(
    parameter int N          = POLY_N,
    parameter int Q          = POLY_Q,
    parameter int COEF_W     = POLY_COEF_W,
    parameter int RATE_BYTES = POLY_RATE_BYTES
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [RATE_BYTES*8-1:0] blk_data,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    output logic [N*COEF_W-1:0]     a_out,
    output logic                    done,
    output logic                    err
`ifdef POLY_SAMPLE_STAT_EN
    ,
    output logic [7:0]              blk_cnt,
    output logic [15:0]             rej_cnt
`endif
);

    localparam int POS_W = $clog2(2 * RATE_BYTES);
    localparam int CNT_W = $clog2(N);

    if (RATE_BYTES % 3 != 0) begin : g_bad_rate
        $error("poly_sample_rej: RATE_BYTES must be divisible by 3");
    end

    state_t                  state_reg, state_next;
    logic [1:0]              mode_reg;
    logic [RATE_BYTES*8-1:0] blk_reg;
    logic [POS_W-1:0]        pos_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [COEF_W-1:0]       coef_mem [N];

    logic                    cand_accept;
    logic [COEF_W-1:0]       cand_coef;
    logic                    cand_last;
    logic                    blk_take;
    logic                    final_accept;

    poly_sample_cand #(
        .RATE_BYTES (RATE_BYTES),
        .Q          (Q),
        .COEF_W     (COEF_W),
        .POS_W      (POS_W)
    ) u_cand (
        .blk    (blk_reg),
        .pos    (pos_reg),
        .mode   (mode_reg),
        .accept (cand_accept),
        .coef   (cand_coef),
        .last   (cand_last)
    );

    assign blk_take     = blk_valid && blk_ready;
    assign final_accept = cand_accept && (cnt_reg == CNT_W'(N - 1));

    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_flat
        assign a_out[gi*COEF_W +: COEF_W] = coef_mem[gi];
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state_reg;
        blk_ready  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (mode == MODE_RSVD) state_next = ST_DONE;
                    else                   state_next = ST_WAIT_BLK;
                end
            end
            ST_WAIT_BLK: begin
                blk_ready = 1'b1;
                if (blk_valid) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                // completing the polynomial wins over running out of block
                if (final_accept)   state_next = ST_DONE;
                else if (cand_last) state_next = ST_WAIT_BLK;
            end
            ST_DONE: begin
                done = 1'b1;
                err  = (mode_reg == MODE_RSVD);
                if (!start) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: mode latch, block buffer, candidate pointer, coefficient store
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_reg <= '0;
            blk_reg  <= '0;
            pos_reg  <= '0;
            cnt_reg  <= '0;
            for (int i = 0; i < N; i++) coef_mem[i] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mode_reg <= mode;
                        cnt_reg  <= '0;
                        for (int i = 0; i < N; i++) coef_mem[i] <= '0;
                    end
                end
                ST_WAIT_BLK: begin
                    if (blk_take) begin
                        blk_reg <= blk_data;
                        pos_reg <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (cand_accept) begin
                        coef_mem[cnt_reg] <= cand_coef;
                        cnt_reg           <= cnt_reg + 1'b1;
                    end
                    if (!cand_last) pos_reg <= pos_reg + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef POLY_SAMPLE_STAT_EN
    logic [7:0]  blk_cnt_reg;
    logic [15:0] rej_cnt_reg;

    assign blk_cnt = blk_cnt_reg;
    assign rej_cnt = rej_cnt_reg;

    // Saturating block / rejection statistics, cleared on each new request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt_reg <= '0;
            rej_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                blk_cnt_reg <= '0;
                rej_cnt_reg <= '0;
            end else begin
                if (state_reg == ST_WAIT_BLK && blk_take && blk_cnt_reg != 8'hFF)
                    blk_cnt_reg <= blk_cnt_reg + 1'b1;
                if (state_reg == ST_SAMPLE && !cand_accept && rej_cnt_reg != 16'hFFFF)
                    rej_cnt_reg <= rej_cnt_reg + 1'b1;
            end
        end
    end
`endif

endmodule
